// File: rtl/vdot_feeder.sv
// vdot_feeder: packs up to 16 element pairs into lane buses, kicks the dot-product stage,
// then waits for vDone (with timeout) and holds the captured result until downstream takes it.
module vdot_feeder #(
  parameter int DONE_TIMEOUT = 8
) (
  input  logic         Clk1,
  input  logic         Rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [15:0]  in_a,
  input  logic [15:0]  in_b,
  input  logic         in_last,
  output logic [255:0] vA,
  output logic [255:0] vB,
  output logic         vStart,
  input  logic         vDone,
  input  logic [15:0]  vOut,
  input  logic         vV,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [15:0]  res_data,
  output logic         res_ovf,
  output logic         res_timeout
);
  localparam int CW = $clog2(DONE_TIMEOUT + 1);
  localparam logic [CW-1:0] LIM = CW'(DONE_TIMEOUT - 1);
  typedef enum logic [1:0] {LOAD, START, WAIT, RESULT} state_t;
  state_t state, nxt;
  logic [3:0] k;
  logic [CW-1:0] cnt;
  logic take, expire;
  assign in_ready = state == LOAD;
  assign vStart = state == START;
  assign res_valid = state == RESULT;
  assign take = in_valid && in_ready;
  // expiry lands on the last allowed WAIT cycle, so WAIT lasts at most DONE_TIMEOUT cycles
  assign expire = cnt == LIM;
  always_comb begin
    nxt = state;
    unique case (state)
      LOAD:   nxt = take && (k == 4'd15 || in_last) ? START : LOAD;
      START:  nxt = WAIT;
      WAIT:   nxt = vDone || expire ? RESULT : WAIT;
      RESULT: nxt = res_ready ? LOAD : RESULT;
    endcase
  end
  always_ff @(posedge Clk1 or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= LOAD;
      k <= '0;
      cnt <= '0;
      vA <= '0;
      vB <= '0;
      res_data <= '0;
      res_ovf <= 1'b0;
      res_timeout <= 1'b0;
    end else begin
      state <= nxt;
      if (take) begin
        vA[{k, 4'd0} +: 16] <= in_a;
        vB[{k, 4'd0} +: 16] <= in_b;
        k <= k + 4'd1;
      end
      if (state == START) cnt <= '0;
      if (state == WAIT) begin
        cnt <= cnt + CW'(1);
        // vDone takes priority over a coinciding expiry
        if (vDone) begin
          res_data <= vOut;
          res_ovf <= vV;
          res_timeout <= 1'b0;
        end else if (expire) begin
          res_data <= '0;
          res_ovf <= 1'b0;
          res_timeout <= 1'b1;
        end
      end
      if (res_valid && res_ready) begin
        vA <= '0;
        vB <= '0;
        k <= '0;
      end
    end
  end
endmodule

// File: tb/tb_vdot_feeder.sv
// tb_vdot_feeder: scoreboard bench with a behavioural dot-product stage answering vStart.
module tb_vdot_feeder;
  logic Clk1 = 1'b0, Rst_n = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, res_ready = 1'b0;
  logic [15:0] in_a = '0, in_b = '0;
  logic [255:0] vA, vB;
  logic vStart, in_ready, res_valid, res_ovf, res_timeout;
  logic vDone = 1'b0, vV = 1'b0;
  logic [15:0] vOut = '0, res_data;
  vdot_feeder #(.DONE_TIMEOUT(8)) dut (
    .Clk1(Clk1), .Rst_n(Rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .vA(vA), .vB(vB),
    .vStart(vStart), .vDone(vDone), .vOut(vOut), .vV(vV),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_ovf(res_ovf), .res_timeout(res_timeout)
  );
  always #5 Clk1 = ~Clk1;
  int cyc = 0;
  always @(posedge Clk1) cyc <= cyc + 1;
  typedef struct packed {logic [15:0] d; logic o; logic t;} res_t;
  res_t sbq[$];
  res_t e;
  int checks = 0, errors = 0, h_cyc = 0;
  logic [15:0] sa [16];
  logic [15:0] sb [16];
  // behavioural stage: answers stage_delay cycles after vStart (0 = never answers)
  int stage_delay = 1, pend = 0, acc;
  logic force_ovf = 1'b0;
  logic [15:0] dot;
  always @(negedge Clk1) begin
    vDone = 1'b0;
    if (!Rst_n) pend = 0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        vDone = 1'b1;
        vOut = dot;
        vV = force_ovf;
      end
    end
    if (vStart && stage_delay > 0) begin
      acc = 0;
      for (int i = 0; i < 16; i++) acc += $signed(vA[16*i +: 16]) * $signed(vB[16*i +: 16]);
      dot = acc[15:0];
      pend = stage_delay;
    end
  end
  task automatic send(input int n, input bit use_last, input bit complete);
    logic [255:0] ea, eb;
    int s, w;
    ea = '0;
    eb = '0;
    s = 0;
    for (int i = 0; i < n; i++) begin
      ea[16*i +: 16] = sa[i];
      eb[16*i +: 16] = sb[i];
      s += $signed(sa[i]) * $signed(sb[i]);
      in_valid = 1'b1;
      in_a = sa[i];
      in_b = sb[i];
      in_last = use_last && i == n - 1;
      w = 0;
      while (!in_ready && w < 50) begin
        @(negedge Clk1);
        w++;
      end
      if (!in_ready) begin
        checks++;
        errors++;
        $display("FAIL send: in_ready stayed 0 for element %0d", i);
      end
      @(negedge Clk1);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    if (complete) begin
      h_cyc = cyc;
      checks++;
      if (vStart !== 1'b1) begin
        errors++;
        $display("FAIL vstart: got %b want 1 one cycle after last handshake", vStart);
      end
      checks++;
      if (vA !== ea || vB !== eb) begin
        errors++;
        $display("FAIL lanes: vA=%h vB=%h want vA=%h vB=%h", vA, vB, ea, eb);
      end
      if (stage_delay == 0 || stage_delay > 8) sbq.push_back('{16'd0, 1'b0, 1'b1});
      else sbq.push_back('{s[15:0], force_ovf, 1'b0});
    end
  endtask
  task automatic wait_res(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (res_valid) ok = 1;
      else @(negedge Clk1);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_res: res_valid not seen within %0d cycles", budget);
    end
  endtask
  task automatic accept();
    res_ready = 1'b1;
    @(negedge Clk1);
    res_ready = 1'b0;
  endtask
  task automatic test_reset();
    repeat (2) @(negedge Clk1);
    checks++;
    if ({in_ready, vStart, res_valid, res_data, res_ovf, res_timeout} !== {1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_ctl: rdy=%b st=%b rv=%b d=%h o=%b t=%b want 1 0 0 0000 0 0", in_ready, vStart, res_valid, res_data, res_ovf, res_timeout);
    end
    checks++;
    if (vA !== '0 || vB !== '0) begin
      errors++;
      $display("FAIL reset_bus: vA=%h vB=%h want 0", vA, vB);
    end
    Rst_n = 1'b1;
  endtask
  task automatic test_full();
    stage_delay = 1;
    for (int i = 0; i < 16; i++) begin
      sa[i] = 16'd1;
      sb[i] = 16'd2;
    end
    send(16, 0, 1);
    @(negedge Clk1);
    checks++;
    if (vStart !== 1'b0) begin
      errors++;
      $display("FAIL vstart_width: got %b want 0 in second cycle", vStart);
    end
    wait_res(20);
    checks++;
    if (cyc !== h_cyc + 2) begin
      errors++;
      $display("FAIL full_latency: res_valid at +%0d want +2 after vStart", cyc - h_cyc);
    end
    checks++;
    if (res_data !== 16'd32) begin
      errors++;
      $display("FAIL full_data: got %h want 0020", res_data);
    end
    e = sbq.pop_front();
    checks++;
    if ({res_data, res_ovf, res_timeout} !== e) begin
      errors++;
      $display("FAIL full_sb: got %h/%b/%b want %h/%b/%b", res_data, res_ovf, res_timeout, e.d, e.o, e.t);
    end
    accept();
  endtask
  task automatic test_short();
    sa[0] = 16'd3; sa[1] = 16'hfffe; sa[2] = 16'd7;
    sb[0] = 16'd5; sb[1] = 16'd4;    sb[2] = 16'd2;
    send(3, 1, 1);
    checks++;
    if (vA[255:48] !== '0 || vB[255:48] !== '0) begin
      errors++;
      $display("FAIL short_pad: upper lanes vA=%h vB=%h want 0", vA[255:48], vB[255:48]);
    end
    wait_res(20);
    e = sbq.pop_front();
    checks++;
    if ({res_data, res_ovf, res_timeout} !== e || res_data !== 16'd21) begin
      errors++;
      $display("FAIL short_sb: got %h/%b/%b want %h/%b/%b", res_data, res_ovf, res_timeout, e.d, e.o, e.t);
    end
    accept();
  endtask
  task automatic test_backpressure();
    logic [15:0] sd;
    logic so;
    for (int i = 0; i < 5; i++) begin
      sa[i] = 16'($urandom);
      sb[i] = 16'($urandom);
    end
    send(5, 1, 1);
    wait_res(20);
    sd = res_data;
    so = res_ovf;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk1);
      checks++;
      if (res_valid !== 1'b1 || res_data !== sd || res_ovf !== so || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold: cycle %0d rv=%b d=%h o=%b rdy=%b want 1 %h %b 0", i, res_valid, res_data, res_ovf, in_ready, sd, so);
      end
    end
    e = sbq.pop_front();
    checks++;
    if ({res_data, res_ovf, res_timeout} !== e) begin
      errors++;
      $display("FAIL bp_sb: got %h/%b/%b want %h/%b/%b", res_data, res_ovf, res_timeout, e.d, e.o, e.t);
    end
    accept();
    checks++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0 || vA !== '0 || vB !== '0) begin
      errors++;
      $display("FAIL release: rdy=%b rv=%b vA=%h vB=%h want 1 0 0 0", in_ready, res_valid, vA, vB);
    end
  endtask
  task automatic test_timeout();
    int dl [3] = '{0, 9, 8};
    for (int r = 0; r < 3; r++) begin
      stage_delay = dl[r];
      for (int i = 0; i < 4; i++) begin
        sa[i] = 16'(i + 2 + r);
        sb[i] = 16'(3 * i + 1);
      end
      send(4, 1, 1);
      wait_res(30);
      checks++;
      if (cyc !== h_cyc + 9) begin
        errors++;
        $display("FAIL to_latency: delay %0d res_valid at +%0d want +9", dl[r], cyc - h_cyc);
      end
      e = sbq.pop_front();
      checks++;
      if ({res_data, res_ovf, res_timeout} !== e) begin
        errors++;
        $display("FAIL to_sb: delay %0d got %h/%b/%b want %h/%b/%b", dl[r], res_data, res_ovf, res_timeout, e.d, e.o, e.t);
      end
      // a late vDone arrives during RESULT and must not disturb the held result
      @(negedge Clk1);
      checks++;
      if ({res_data, res_ovf, res_timeout} !== e) begin
        errors++;
        $display("FAIL to_hold: delay %0d got %h/%b/%b want %h/%b/%b", dl[r], res_data, res_ovf, res_timeout, e.d, e.o, e.t);
      end
      accept();
    end
    stage_delay = 1;
  endtask
  task automatic test_overflow();
    force_ovf = 1'b1;
    sa[0] = 16'h7fff; sa[1] = 16'h7fff;
    sb[0] = 16'h7fff; sb[1] = 16'h7fff;
    send(2, 1, 1);
    wait_res(20);
    e = sbq.pop_front();
    checks++;
    if ({res_data, res_ovf, res_timeout} !== e || res_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf: got %h/%b/%b want %h/1/0", res_data, res_ovf, res_timeout, e.d);
    end
    accept();
    force_ovf = 1'b0;
  endtask
  task automatic test_reset_mid();
    stage_delay = 0;
    for (int i = 0; i < 16; i++) begin
      sa[i] = 16'($urandom);
      sb[i] = 16'($urandom);
    end
    send(4, 1, 1);
    repeat (3) @(negedge Clk1);
    #2 Rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, vStart, res_valid, res_data, res_ovf, res_timeout} !== {1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0} || vA !== '0 || vB !== '0) begin
      errors++;
      $display("FAIL rst_wait: rdy=%b st=%b rv=%b d=%h o=%b t=%b vA=%h want reset values", in_ready, vStart, res_valid, res_data, res_ovf, res_timeout, vA);
    end
    void'(sbq.pop_back());
    @(negedge Clk1);
    Rst_n = 1'b1;
    stage_delay = 1;
    send(7, 0, 0);
    #2 Rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || vStart !== 1'b0 || vA !== '0 || vB !== '0) begin
      errors++;
      $display("FAIL rst_load: rdy=%b st=%b vA=%h vB=%h want 1 0 0 0", in_ready, vStart, vA, vB);
    end
    @(negedge Clk1);
    Rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready: in_ready=%b want 1 after release", in_ready);
    end
    sa[0] = 16'd9; sa[1] = 16'hfffd;
    sb[0] = 16'd4; sb[1] = 16'd6;
    send(2, 1, 1);
    wait_res(20);
    e = sbq.pop_front();
    checks++;
    if ({res_data, res_ovf, res_timeout} !== e || res_data !== 16'd18) begin
      errors++;
      $display("FAIL rst_next: got %h/%b/%b want %h/%b/%b", res_data, res_ovf, res_timeout, e.d, e.o, e.t);
    end
    accept();
  endtask
  task automatic test_random();
    int n;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 16);
      stage_delay = $urandom_range(1, 8);
      force_ovf = 1'($urandom);
      for (int i = 0; i < 16; i++) begin
        sa[i] = 16'($urandom);
        sb[i] = 16'($urandom);
      end
      send(n, n < 16 ? 1'b1 : 1'($urandom), 1);
      wait_res(30);
      checks++;
      if (cyc !== h_cyc + 1 + stage_delay) begin
        errors++;
        $display("FAIL rnd_latency: run %0d res_valid at +%0d want +%0d", r, cyc - h_cyc, 1 + stage_delay);
      end
      e = sbq.pop_front();
      checks++;
      if ({res_data, res_ovf, res_timeout} !== e) begin
        errors++;
        $display("FAIL rnd_sb: run %0d n=%0d got %h/%b/%b want %h/%b/%b", r, n, res_data, res_ovf, res_timeout, e.d, e.o, e.t);
      end
      accept();
    end
    force_ovf = 1'b0;
    stage_delay = 1;
  endtask
  initial begin
    test_reset();
    test_full();
    test_short();
    test_backpressure();
    test_timeout();
    test_overflow();
    test_reset_mid();
    test_random();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d results left unmatched, want 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vdot_feeder.md
VDOT_FEEDER -- requirements
Module: vdot_feeder

Interface
REQ-001 Parameter: DONE_TIMEOUT, default 8, max cycles spent in WAIT for vDone before aborting.
REQ-002 Clk1  input  1  single clock; all state updates on posedge Clk1.
REQ-003 Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream element pair valid.
REQ-005 in_ready  output  1  feeder accepts an element pair this cycle.
REQ-006 in_a, in_b  input  16 each  element pair, 16-bit two's complement.
REQ-007 in_last  input  1  marks the final element of a vector, for vectors shorter than 16.
REQ-008 vA, vB  output  256 each  packed operand buses to the dot-product stage.
REQ-009 vStart  output  1  one-cycle start pulse to the dot-product stage.
REQ-010 vDone  input  1  completion from the dot-product stage.
REQ-011 vOut  input  16  dot-product result.
REQ-012 vV  input  1  dot-product overflow.
REQ-013 res_valid  output  1  result available.
REQ-014 res_ready  input  1  downstream accepts the result.
REQ-015 res_data  output  16  captured result.
REQ-016 res_ovf  output  1  captured overflow.
REQ-017 res_timeout  output  1  result aborted by timeout.

Function
REQ-018 The FSM SHALL have four states: LOAD, START, WAIT, RESULT.
REQ-019 in_ready SHALL be 1 only in LOAD.
REQ-020 In LOAD, each handshake (in_valid & in_ready) SHALL write in_a to vA[16k+15:16k] and in_b to vB[16k+15:16k], where k is the 4-bit element count, then increment k.
REQ-021 LOAD SHALL transition to START on the handshake where k==15 or in_last==1; in_last at k==15 SHALL behave identically to a full vector.
REQ-022 Unwritten lanes SHALL hold zero, so a short vector is zero-padded and contributes 0 product.
REQ-023 vStart SHALL be 1 for exactly the one cycle spent in START; START SHALL always go to WAIT.
REQ-024 vA/vB SHALL stay constant from entry to START until exit from RESULT.
REQ-025 In WAIT, vDone==1 SHALL capture vOut into res_data and vV into res_ovf, clear res_timeout, and go to RESULT.
REQ-026 A WAIT cycle counter SHALL start at 0 on WAIT entry.
REQ-027 If the WAIT counter reaches DONE_TIMEOUT without vDone, the FSM SHALL go to RESULT with res_data=0, res_ovf=0, res_timeout=1.
REQ-028 If vDone and timeout expiry coincide, vDone SHALL win.
REQ-029 vDone outside WAIT SHALL be ignored.
REQ-030 res_valid SHALL be 1 throughout RESULT; res_data, res_ovf and res_timeout SHALL hold stable while res_valid=1 and res_ready=0.
REQ-031 On res_valid & res_ready, the block SHALL clear vA/vB to 0, set k=0, and go to LOAD; the next element is accepted no earlier than the following cycle.
REQ-032 Latency with a single-cycle downstream: last handshake at cycle t -> vStart at t+1 -> vDone sampled at t+2 -> res_valid at t+3.

Reset
REQ-033 Asserting Rst_n=0 at any time, including mid-LOAD or mid-WAIT, SHALL immediately force LOAD, k=0, WAIT counter=0, vA=vB=0, vStart=0, res_valid=0, res_data=0, res_ovf=0, res_timeout=0; in_ready SHALL be 1 while in LOAD.
REQ-034 After Rst_n deasserts, the first Clk1 edge SHALL accept a valid element.

Verification
REQ-035 Full vector: 16 pairs, all a=1 and b=2 (Q-format per dot-product stage), back-to-back -> vStart one cycle after the 16th handshake; res_data equals the stage's vOut; res_valid at t+3.
REQ-036 Short vector: 3 pairs, in_last on the 3rd -> lanes 3..15 of vA/vB read 0 during vStart; result matches the 3-term dot product.
REQ-037 Backpressure: res_ready held 0 for 10 cycles -> res_valid, res_data and res_ovf stable; in_ready=0 throughout; after res_ready=1, vA=vB=0 and in_ready=1 the next cycle.
REQ-038 Timeout: vDone tied 0, DONE_TIMEOUT=8 -> RESULT with res_timeout=1 and res_data=0; vDone pulsed on the expiry cycle -> res_timeout=0 and vOut captured.
REQ-039 Overflow passthrough: downstream drives vV=1 with vDone -> res_ovf=1.
REQ-040 Reset mid-operation: Rst_n low during WAIT and again after the 7th LOAD handshake -> all outputs at reset values; the next vector loads from lane 0 with clean zero padding.
